// File: rtl/sat_acc_if.sv
// Signal bundle between the saturating accumulator and its environment.
// The environment includes the sample source, the result consumer and the external adder.
interface sat_acc_if #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
);
  logic               start;
  logic [COUNT_W-1:0] length;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;
  logic [WIDTH-1:0]   add_a;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_result;
  logic               add_overflow;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_sat;
  logic               out_ready;
  logic               busy;

  modport master (
    output start, length, in_valid, in_data, add_result, add_overflow, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  start, length, in_valid, in_data, add_result, add_overflow, out_ready,
    output in_ready, add_a, add_b, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/sat_accumulator.sv
// Streams a run of signed samples through an external adder and accumulates them with
// clamping on overflow; presents the sum and a sticky saturation flag.
//   state | meaning
//   IDLE  | waiting for start; acc/sat keep the last run's result
//   ACCUM | accepting samples until the run length is used up
//   DONE  | result presented on out_valid until out_ready
module sat_accumulator #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input logic     clk,
  input logic     rst_n,
  sat_acc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic [COUNT_W-1:0] remaining, remaining_nxt;
  logic               sat, sat_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      sat       <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      sat       <= sat_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    sat_nxt       = sat;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          sat_nxt = 1'b0;
          if (bus.length != '0) begin
            remaining_nxt = bus.length;
            state_nxt     = ACCUM;
          end else begin
            remaining_nxt = '0;
            state_nxt     = DONE;
          end
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          // Overflow means acc and sample share a sign, so acc's sign picks the rail.
          acc_nxt = bus.add_overflow ? (acc[WIDTH-1] ? MAX_NEG : MAX_POS) : bus.add_result;
          sat_nxt = sat | bus.add_overflow;
          if (remaining != '0) remaining_nxt = remaining - COUNT_W'(1);
          if (remaining == COUNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = acc;
  assign bus.out_sat   = sat;
  assign bus.add_a     = acc;
  assign bus.add_b     = bus.in_data;

endmodule
